// File: rtl/true_dual_port_bytewe_ram.sv
// True dual-port block RAM, one clock, per-byte write enables, pipelined reads.
// Tracks cross-port address collisions with a pulse and a saturating counter.
module true_dual_port_bytewe_ram #(
    parameter int    NB_COL       = 4,
    parameter int    COL_WIDTH    = 8,
    parameter int    RAM_DEPTH    = 1024,
    parameter string WRITE_MODE   = "READ_FIRST",
    parameter int    READ_LATENCY = 2,
    localparam int   W            = NB_COL * COL_WIDTH,
    localparam int   AW           = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              ena,
    input  logic [NB_COL-1:0] wea,
    input  logic [AW-1:0]     addra,
    input  logic [W-1:0]      dina,
    output logic [W-1:0]      douta,
    output logic              douta_valid,
    input  logic              enb,
    input  logic [NB_COL-1:0] web,
    input  logic [AW-1:0]     addrb,
    input  logic [W-1:0]      dinb,
    output logic [W-1:0]      doutb,
    output logic              doutb_valid,
    output logic              coll,
    output logic [15:0]       coll_cnt
);

    localparam bit WF = (WRITE_MODE == "WRITE_FIRST");
    localparam bit NC = (WRITE_MODE == "NO_CHANGE");
    localparam int L  = READ_LATENCY;

    logic [W-1:0] mem [RAM_DEPTH];

    logic              act_a, act_b;
    logic              in_a, in_b;
    logic              wr_a, wr_b;
    logic [W-1:0]      old_a, old_b;
    logic [W-1:0]      mrg_a, mrg_b;
    logic [W-1:0]      rd [2];
    logic              vin [2];
    logic              coll_now;

    logic [W-1:0]      pd [2][L];
    logic              pv [2][L];

    assign act_a = ena & ~rstb;
    assign act_b = enb & ~rstb;
    assign in_a  = {1'b0, addra} < (AW+1)'(RAM_DEPTH);
    assign in_b  = {1'b0, addrb} < (AW+1)'(RAM_DEPTH);
    assign wr_a  = act_a & in_a;
    assign wr_b  = act_b & in_b;
    assign old_a = in_a ? mem[addra] : '0;
    assign old_b = in_b ? mem[addrb] : '0;

    // Own-port view of a write: written lanes new, untouched lanes old.
    always_comb begin
        mrg_a = old_a;
        mrg_b = old_b;
        for (int i = 0; i < NB_COL; i++) begin
            if (wea[i]) mrg_a[i*COL_WIDTH +: COL_WIDTH] = dina[i*COL_WIDTH +: COL_WIDTH];
            if (web[i]) mrg_b[i*COL_WIDTH +: COL_WIDTH] = dinb[i*COL_WIDTH +: COL_WIDTH];
        end
    end

    always_comb begin
        rd[0]  = (WF && |wea && in_a) ? mrg_a : old_a;
        rd[1]  = (WF && |web && in_b) ? mrg_b : old_b;
        vin[0] = act_a & ~(NC & |wea);
        vin[1] = act_b & ~(NC & |web);
    end

    // Port A lanes are assigned last so they win on a shared-lane collision.
    always_ff @(posedge clka) begin
        for (int i = 0; i < NB_COL; i++) begin
            if (wr_b && web[i])
                mem[addrb][i*COL_WIDTH +: COL_WIDTH] <= dinb[i*COL_WIDTH +: COL_WIDTH];
        end
        for (int i = 0; i < NB_COL; i++) begin
            if (wr_a && wea[i])
                mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
        end
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < L; k++) begin
                    pd[p][k] <= '0;
                    pv[p][k] <= 1'b0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pv[p][0] <= vin[p];
                if (vin[p]) pd[p][0] <= rd[p];
                for (int k = 1; k < L; k++) begin
                    pv[p][k] <= pv[p][k-1];
                    if (pv[p][k-1]) pd[p][k] <= pd[p][k-1];
                end
            end
        end
    end

    assign douta       = pd[0][L-1];
    assign douta_valid = pv[0][L-1];
    assign doutb       = pd[1][L-1];
    assign doutb_valid = pv[1][L-1];

    assign coll_now = act_a & act_b & (addra == addrb) & (|wea | |web);

    always_ff @(posedge clka) begin
        if (rstb) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= coll_now;
            if (coll_now && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
        end
    end

endmodule
